// File: rtl/apb_pkg.sv
// Shared types for the APB multi-requester: FSM encoding and default PPROT width.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   localparam int PROT_W = 3;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational window decoder: slave i owns [BASE_ADDR + i*2^WIN_LOG2, +2^WIN_LOG2-1].
// Addresses below the base never wrap into a window; beyond the last slave is a miss.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    NUM_SLAVES = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    WIN_LOG2   = 5
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  hit
);

   logic [ADDR_WIDTH-1:0] off;
   logic [ADDR_WIDTH-1:0] idx;

   assign off = addr - BASE_ADDR;
   assign idx = off >> WIN_LOG2;
   assign hit = (addr >= BASE_ADDR) && (idx < ADDR_WIDTH'(NUM_SLAVES));

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
      assign sel[i] = hit && (idx == ADDR_WIDTH'(i));
   end

endmodule

// File: rtl/apb_multi_requester.sv
// APB requester bridging a valid/ready command port to NUM_SLAVES completers.
// One command in flight; the response cycle is IDLE so the next command can be
// accepted in the same cycle the previous response is pulsed.
module apb_multi_requester
   import apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    STRB_WIDTH = DATA_WIDTH/8,
   parameter int                    PROT_WIDTH = PROT_W,
   parameter int                    NUM_SLAVES = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    WIN_LOG2   = 5,
   parameter int                    TIMEOUT    = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESET,
   input  logic                             MREQ,
   output logic                             MREADY,
   input  logic [ADDR_WIDTH-1:0]            MADDR,
   input  logic                             MWRITE,
   input  logic [DATA_WIDTH-1:0]            MWDATA,
   input  logic [STRB_WIDTH-1:0]            MSTRB,
   input  logic [PROT_WIDTH-1:0]            MPROT,
   output logic                             MRSP_VALID,
   output logic [DATA_WIDTH-1:0]            MRDATA,
   output logic                             MSLVERR,
   output logic [NUM_SLAVES-1:0]            PSEL,
   output logic                             PENABLE,
   output logic [ADDR_WIDTH-1:0]            PADDR,
   output logic                             PWRITE,
   output logic [DATA_WIDTH-1:0]            PWDATA,
   output logic [STRB_WIDTH-1:0]            PSTRB,
   output logic [PROT_WIDTH-1:0]            PPROT,
   input  logic [NUM_SLAVES-1:0]            PREADY,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]            PSLVERR
);

   // Counter needs at least one bit even when the timeout is disabled.
   localparam int             TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]  TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t                  state, state_nxt;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_hit;
   logic [TW-1:0]           tcnt;
   logic                    accept, sel_ready, sel_err, timeout_hit, done;
   logic [DATA_WIDTH-1:0]   sel_rdata;

   apb_addr_decoder #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLAVES (NUM_SLAVES),
      .BASE_ADDR  (BASE_ADDR),
      .WIN_LOG2   (WIN_LOG2)
   ) u_dec (
      .addr (MADDR),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   assign MREADY      = (state == ST_IDLE);
   assign accept      = MREQ && MREADY;
   // PSEL is one-hot, so masking with it ignores non-selected completers.
   assign sel_ready   = |(PREADY & PSEL);
   assign sel_err     = |(PSLVERR & PSEL);
   assign timeout_hit = (TIMEOUT != 0) && (tcnt == TO_LAST);
   assign done        = (state == ST_ERR) ||
                        ((state == ST_ACCESS) && (sel_ready || timeout_hit));

   // Read-data mux over the selected completer.
   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Next-state logic; PREADY is only looked at in ACCESS.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = dec_hit ? ST_SETUP : ST_ERR;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: if (sel_ready || timeout_hit) state_nxt = ST_IDLE;
         ST_ERR:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge PCLK) begin
      if (PRESET) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // APB command registers, timeout counter and the one-cycle response.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PSEL       <= '0;
         PENABLE    <= 1'b0;
         PADDR      <= '0;
         PWRITE     <= 1'b0;
         PWDATA     <= '0;
         PSTRB      <= '0;
         PPROT      <= '0;
         tcnt       <= '0;
         MRSP_VALID <= 1'b0;
         MRDATA     <= '0;
         MSLVERR    <= 1'b0;
      end else begin
         if (accept) begin
            PSEL   <= dec_sel;
            PADDR  <= MADDR;
            PWRITE <= MWRITE;
            PWDATA <= MWDATA;
            PSTRB  <= MSTRB;
            PPROT  <= MPROT;
            tcnt   <= '0;
         end else if (done) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            PPROT   <= '0;
         end else if (state == ST_SETUP) begin
            PENABLE <= 1'b1;
         end
         if (state == ST_ACCESS) tcnt <= tcnt + 1'b1;
         // PREADY wins over a timeout landing in the same cycle.
         MRSP_VALID <= done;
         MSLVERR    <= (state == ST_ERR) ||
                       ((state == ST_ACCESS) && (sel_ready ? sel_err : timeout_hit));
         MRDATA     <= ((state == ST_ACCESS) && sel_ready && !PWRITE) ? sel_rdata : '0;
      end
   end

endmodule
